// File: rtl/pipe_ctrl.sv
// Pipeline control: turns the hazard unit's stall vector into per-register
// load enables and flushes, tracks which stages hold real instructions, and
// keeps saturating stall/flush/retire counters plus a sticky illegal-code flag.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_stall,
    input  logic             i_fetch_valid,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_clr,
    output logic             o_idex_clr,
    output logic             o_exmem_clr,
    output logic             o_v_id,
    output logic             o_v_ex,
    output logic             o_v_mem,
    output logic             o_v_wb,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_retire_cnt,
    output logic             o_err
);

    localparam int unsigned CODE_W = 2;

    localparam logic [CODE_W-1:0] CODE_RUN   = 2'b00;
    localparam logic [CODE_W-1:0] CODE_ILL   = 2'b10;
    localparam logic [CODE_W-1:0] CODE_FLUSH = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STALL  = 2'b01,
        ST_REFILL = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CODE_W-1:0] ifid_code;
    logic [CODE_W-1:0] idex_code;
    logic [CODE_W-1:0] exmem_code;

    logic pc_hold;
    logic wb_hold;
    logic ifid_run,   ifid_flush,   ifid_hold;
    logic idex_run,   idex_flush,   idex_hold;
    logic exmem_run,  exmem_flush,  exmem_hold;
    logic any_flush;
    logic any_hold;
    logic any_illegal;

    logic v_id_q,  v_id_d;
    logic v_ex_q,  v_ex_d;
    logic v_mem_q, v_mem_d;
    logic v_wb_q,  v_wb_d;

    logic stall_inc;
    logic flush_inc;
    logic retire_inc;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] retire_cnt_q;
    logic             err_q;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic             en);
        logic [CNT_W-1:0] res;
        res = val;
        if (en && (val != CNT_MAX)) begin
            res = val + CNT_W'(1);
        end
        return res;
    endfunction

    // Split the stall vector into per-stage run/hold/flush; code 10 acts as hold.
    always_comb begin
        ifid_code   = i_stall[6:5];
        idex_code   = i_stall[4:3];
        exmem_code  = i_stall[2:1];
        pc_hold     = i_stall[7];
        wb_hold     = i_stall[0];

        ifid_run    = (ifid_code  == CODE_RUN);
        ifid_flush  = (ifid_code  == CODE_FLUSH);
        ifid_hold   = ~ifid_run & ~ifid_flush;

        idex_run    = (idex_code  == CODE_RUN);
        idex_flush  = (idex_code  == CODE_FLUSH);
        idex_hold   = ~idex_run & ~idex_flush;

        exmem_run   = (exmem_code == CODE_RUN);
        exmem_flush = (exmem_code == CODE_FLUSH);
        exmem_hold  = ~exmem_run & ~exmem_flush;

        any_flush   = ifid_flush | idex_flush | exmem_flush;
        any_hold    = pc_hold | wb_hold | ifid_hold | idex_hold | exmem_hold;
        any_illegal = (ifid_code == CODE_ILL) | (idex_code == CODE_ILL) |
                      (exmem_code == CODE_ILL);
    end

    // Register enables and flushes come straight from the decoded codes.
    assign o_pc_en     = ~pc_hold;
    assign o_memwb_en  = ~wb_hold;
    assign o_ifid_en   = ifid_run;
    assign o_idex_en   = idex_run;
    assign o_exmem_en  = exmem_run;
    assign o_ifid_clr  = ifid_flush;
    assign o_idex_clr  = idex_flush;
    assign o_exmem_clr = exmem_flush;

    // Stage-valid next state: a running stage behind a stalled or flushed one takes a bubble.
    always_comb begin
        v_id_d  = v_id_q;
        v_ex_d  = v_ex_q;
        v_mem_d = v_mem_q;
        v_wb_d  = v_wb_q;

        if (ifid_run) begin
            v_id_d = i_fetch_valid & ~pc_hold;
        end else if (ifid_flush) begin
            v_id_d = 1'b0;
        end

        if (idex_run) begin
            v_ex_d = v_id_q & ifid_run;
        end else if (idex_flush) begin
            v_ex_d = 1'b0;
        end

        if (exmem_run) begin
            v_mem_d = v_ex_q & idex_run;
        end else if (exmem_flush) begin
            v_mem_d = 1'b0;
        end

        if (!wb_hold) begin
            v_wb_d = v_mem_q & exmem_run;
        end
    end

    // Stage-valid registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v_id_q  <= 1'b0;
            v_ex_q  <= 1'b0;
            v_mem_q <= 1'b0;
            v_wb_q  <= 1'b0;
        end else begin
            v_id_q  <= v_id_d;
            v_ex_q  <= v_ex_d;
            v_mem_q <= v_mem_d;
            v_wb_q  <= v_wb_d;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush beats hold; REFILL waits for EX to hold a real instruction.
    always_comb begin
        state_d = state_q;
        if (any_flush) begin
            state_d = ST_REFILL;
        end else if (any_hold) begin
            state_d = ST_STALL;
        end else if (state_q == ST_REFILL) begin
            state_d = v_ex_q ? ST_RUN : ST_REFILL;
        end else begin
            state_d = ST_RUN;
        end
    end

    // Counter increment conditions.
    always_comb begin
        stall_inc  = any_hold & ~any_flush;
        flush_inc  = any_flush;
        retire_inc = v_wb_q & ~wb_hold;
    end

    // Saturating performance counters and sticky illegal-code flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            stall_cnt_q  <= sat_inc(stall_cnt_q,  stall_inc);
            flush_cnt_q  <= sat_inc(flush_cnt_q,  flush_inc);
            retire_cnt_q <= sat_inc(retire_cnt_q, retire_inc);
            err_q        <= err_q | any_illegal;
        end
    end

    assign o_v_id       = v_id_q;
    assign o_v_ex       = v_ex_q;
    assign o_v_mem      = v_mem_q;
    assign o_v_wb       = v_wb_q;
    assign o_state      = state_q;
    assign o_stall_cnt  = stall_cnt_q;
    assign o_flush_cnt  = flush_cnt_q;
    assign o_retire_cnt = retire_cnt_q;
    assign o_err        = err_q;

endmodule
